// File: rtl/onchip_mem_arbiter_if.sv
// Requester-side Avalon-MM style port and the memory s1 port
// used by the two-requester on-chip memory arbiter.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write,
        output writedata, byteenable,
        input  waitrequest, readdata,
        input  readdatavalid
    );

    modport slave (
        input  address, read, write,
        input  writedata, byteenable,
        output waitrequest, readdata,
        output readdatavalid
    );
endinterface

interface onchip_mem_s1_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                clken;
    logic                chipselect;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                reset_req;

    modport master (
        output address, clken, chipselect,
        output write, writedata, byteenable,
        output reset_req,
        input  readdata
    );

    modport slave (
        input  address, clken, chipselect,
        input  write, writedata, byteenable,
        input  reset_req,
        output readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory
// between requesters A and B, with in-order read return tagging.
module onchip_mem_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    onchip_mem_arbiter_if.slave  a,
    onchip_mem_arbiter_if.slave  b,
    onchip_mem_s1_if.master      mem
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e last_grant;
    port_e win;

    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic rd_issue;

    logic  pipe_vld  [MEM_RD_LAT];
    port_e pipe_port [MEM_RD_LAT];

    logic  exit_a;
    logic  exit_b;

    always_comb begin
        req_a = a.read | a.write;
        req_b = b.read | b.write;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            unique case (1'b1)
                (req_a && !req_b): gnt_a = 1'b1;
                (req_b && !req_a): gnt_b = 1'b1;
                (req_a && req_b): begin
                    if (last_grant == PORT_B)
                        gnt_a = 1'b1;
                    else
                        gnt_b = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Idle cycles keep the mux pointed at the last winner.
    always_comb begin
        win = last_grant;
        if (gnt_a)
            win = PORT_A;
        else if (gnt_b)
            win = PORT_B;
    end

    always_comb begin
        rd_issue = (gnt_a && a.read && !a.write)
                 | (gnt_b && b.read && !b.write);
    end

    always_comb begin
        a.waitrequest  = !gnt_a;
        b.waitrequest  = !gnt_b;
        mem.clken      = !reset;
        mem.reset_req  = reset;
        mem.chipselect = gnt_a | gnt_b;
        mem.write      = 1'b0;
        mem.address    = '0;
        mem.writedata  = '0;
        mem.byteenable = '0;
        if (gnt_a)
            mem.write = a.write;
        else if (gnt_b)
            mem.write = b.write;
        if (!reset) begin
            if (win == PORT_B) begin
                mem.address    = b.address;
                mem.writedata  = b.writedata;
                mem.byteenable = b.byteenable;
            end else begin
                mem.address    = a.address;
                mem.writedata  = a.writedata;
                mem.byteenable = a.byteenable;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_B;
        end else if (gnt_a || gnt_b) begin
            last_grant <= win;
        end
    end

    // Tag pipeline mirrors the memory read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_port[i] <= PORT_A;
            end
        end else begin
            pipe_vld[0]  <= rd_issue;
            pipe_port[0] <= win;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
        end
    end

    always_comb begin
        exit_a = pipe_vld[MEM_RD_LAT-1]
               && (pipe_port[MEM_RD_LAT-1] == PORT_A);
        exit_b = pipe_vld[MEM_RD_LAT-1]
               && (pipe_port[MEM_RD_LAT-1] == PORT_B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a.readdatavalid <= 1'b0;
            b.readdatavalid <= 1'b0;
            a.readdata      <= '0;
            b.readdata      <= '0;
        end else begin
            a.readdatavalid <= exit_a;
            b.readdatavalid <= exit_b;
            if (exit_a)
                a.readdata <= mem.readdata;
            if (exit_b)
                b.readdata <= mem.readdata;
        end
    end

endmodule
